perceptron_cmd_ctrl: RTL and testbench

Byte-level command controller between the UART byte interface and the perceptron datapath. It parses incoming packets, holds the weight and input registers that drive the perceptron, and frames response packets back to the UART transmitter. Read requests return a 7-byte snapshot of both weights and the perceptron result. Write requests update the weights or inputs and return a one-byte acknowledge.

---
 rtl/perceptron_cmd_ctrl.sv | 162 ++++++++++++++++
 tb/tb_perceptron_cmd_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_cmd_ctrl.sv
// Byte-level command controller for the perceptron: parses request packets
// from the UART receiver, owns the weight/input registers feeding the
// datapath, and frames response packets toward the UART transmitter.
module perceptron_cmd_ctrl #(
  parameter int CLK_FREQ       = 12000000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [15:0] weight1,
  output logic [15:0] weight2,
  output logic [15:0] input1,
  output logic [15:0] input2,
  output logic        weights_we,
  output logic        inputs_we,
  input  logic [15:0] result,
  output logic        pkt_error
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_READ  = 8'd5;
  localparam logic [7:0] OP_WR_W  = 8'd50;
  localparam logic [7:0] OP_WR_I  = 8'd51;
  localparam logic [7:0] RSP_READ = 8'd100;
  localparam logic [7:0] RSP_OK   = 8'd101;
  localparam logic [7:0] RSP_ERR  = 8'd102;

  typedef enum logic [2:0] {
    IDLE,
    RX_PAYLOAD,
    COMMIT,
    TX_LOAD,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } state_t;

  state_t           state;
  logic [7:0]       opcode;
  logic [1:0]       byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]      shadow;
  logic [7:0]       tx_buf [0:6];
  logic [2:0]       tx_len;
  logic [2:0]       tx_idx;

  // Packet parser, register bank and response framer in one registered FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      opcode     <= 8'd0;
      byte_cnt   <= 2'd0;
      tmo_cnt    <= '0;
      shadow     <= 32'd0;
      tx_len     <= 3'd0;
      tx_idx     <= 3'd0;
      tx_start   <= 1'b0;
      tx_data    <= 8'd0;
      weight1    <= 16'd0;
      weight2    <= 16'd0;
      input1     <= 16'd0;
      input2     <= 16'd0;
      weights_we <= 1'b0;
      inputs_we  <= 1'b0;
      pkt_error  <= 1'b0;
      for (int i = 0; i < 7; i++) tx_buf[i] <= 8'd0;
    end else begin
      weights_we <= 1'b0;
      inputs_we  <= 1'b0;
      pkt_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            tx_idx <= 3'd0;
            if (rx_data == OP_READ) begin
              // Snapshot is taken now so later result changes cannot leak in
              tx_buf[0] <= RSP_READ;
              tx_buf[1] <= weight1[15:8];
              tx_buf[2] <= weight1[7:0];
              tx_buf[3] <= weight2[15:8];
              tx_buf[4] <= weight2[7:0];
              tx_buf[5] <= result[15:8];
              tx_buf[6] <= result[7:0];
              tx_len    <= 3'd7;
              state     <= TX_LOAD;
            end else if (rx_data == OP_WR_W || rx_data == OP_WR_I) begin
              opcode   <= rx_data;
              byte_cnt <= 2'd0;
              tmo_cnt  <= '0;
              state    <= RX_PAYLOAD;
            end else begin
              tx_buf[0] <= RSP_ERR;
              tx_len    <= 3'd1;
              pkt_error <= 1'b1;
              state     <= TX_LOAD;
            end
          end
        end
        RX_PAYLOAD: begin
          if (rx_valid) begin
            shadow   <= {shadow[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            tmo_cnt  <= '0;
            if (byte_cnt == 2'd3) state <= COMMIT;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abandoned packet: drop the partial payload and report it
            shadow    <= 32'd0;
            pkt_error <= 1'b1;
            tx_buf[0] <= RSP_ERR;
            tx_len    <= 3'd1;
            tx_idx    <= 3'd0;
            state     <= TX_LOAD;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        COMMIT: begin
          // The write strobe lands on the same edge the new values appear
          if (opcode == OP_WR_I) begin
            input1    <= shadow[31:16];
            input2    <= shadow[15:0];
            inputs_we <= 1'b1;
          end else begin
            weight1    <= shadow[31:16];
            weight2    <= shadow[15:0];
            weights_we <= 1'b1;
          end
          tx_buf[0] <= RSP_OK;
          tx_len    <= 3'd1;
          tx_idx    <= 3'd0;
          state     <= TX_LOAD;
        end
        TX_LOAD: begin
          tx_data  <= tx_buf[tx_idx];
          tx_start <= 1'b1;
          state    <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: begin
          if (tx_busy) begin
            tx_start <= 1'b0;
            state    <= TX_WAIT_DONE;
          end
        end
        TX_WAIT_DONE: begin
          if (!tx_busy) begin
            tx_idx <= tx_idx + 3'd1;
            if (tx_idx + 3'd1 == tx_len) state <= IDLE;
            else                         state <= TX_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_cmd_ctrl.sv
// Self-checking bench for perceptron_cmd_ctrl: a UART transmitter model
// collects response bytes, a table of packets plus hand-built corner
// sequences and a randomized phase are checked against a packet-level model.
`timescale 1ns/1ps
module tb_perceptron_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] weight1, weight2, input1, input2;
  logic        weights_we, inputs_we;
  logic [15:0] result;
  logic        pkt_error;

  perceptron_cmd_ctrl #(.CLK_FREQ(100000), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .weight1(weight1), .weight2(weight2), .input1(input1), .input2(input2),
    .weights_we(weights_we), .inputs_we(inputs_we), .result(result),
    .pkt_error(pkt_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] pl;
    logic [15:0] res;
    logic [7:0]  code;
    logic [15:0] w1, w2, i1, i2;
    int          wwe, iwe, err;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  rx_log [$];
  int          wwe_cnt = 0, iwe_cnt = 0, err_cnt = 0;
  logic [31:0] we_w_seen = 0, we_i_seen = 0;
  logic [15:0] m_w1 = 0, m_w2 = 0, m_i1 = 0, m_i2 = 0;

  // UART transmitter model: accepts a byte on tx_start, stays busy a while
  initial begin
    int bcnt;
    bcnt = 0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_busy = 1'b0;
        bcnt = 0;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) tx_busy = 1'b0;
      end else if (tx_start && !tx_busy) begin
        rx_log.push_back(tx_data);
        tx_busy = 1'b1;
        bcnt = $urandom_range(1, 5);
      end
    end
  end

  // Pulse monitor: counts strobes and records register values at the strobe
  always @(negedge clk) begin
    if (!rst) begin
      if (weights_we) begin wwe_cnt++; we_w_seen = {weight1, weight2}; end
      if (inputs_we)  begin iwe_cnt++; we_i_seen = {input1, input2}; end
      if (pkt_error)  err_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (rx_log.size() >= target) break;
      @(negedge clk);
    end
  endtask

  function automatic vec_t mk(logic [7:0] op, logic [31:0] pl, logic [15:0] res,
                              logic [7:0] code, logic [15:0] w1, logic [15:0] w2,
                              logic [15:0] i1, logic [15:0] i2, int wwe, int iwe, int err);
    vec_t v;
    v.op = op; v.pl = pl; v.res = res; v.code = code;
    v.w1 = w1; v.w2 = w2; v.i1 = i1; v.i2 = i2;
    v.wwe = wwe; v.iwe = iwe; v.err = err;
    return v;
  endfunction

  // Packet-level reference: what a request does to the register file
  function automatic vec_t predict(logic [7:0] op, logic [31:0] pl, logic [15:0] res);
    vec_t v;
    v = mk(op, pl, res, 8'd102, m_w1, m_w2, m_i1, m_i2, 0, 0, 0);
    case (op)
      8'd5:  v.code = 8'd100;
      8'd50: begin v.code = 8'd101; v.w1 = pl[31:16]; v.w2 = pl[15:0]; v.wwe = 1; end
      8'd51: begin v.code = 8'd101; v.i1 = pl[31:16]; v.i2 = pl[15:0]; v.iwe = 1; end
      default: v.err = 1;
    endcase
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int start, cw, ci, ce;
    logic [7:0] exp_q [$];
    start = rx_log.size();
    cw = wwe_cnt; ci = iwe_cnt; ce = err_cnt;
    result = v.res;
    send_byte(v.op);
    result = ~v.res;
    if (v.op == 8'd50 || v.op == 8'd51)
      for (int k = 0; k < 4; k++) send_byte(v.pl[31-8*k -: 8]);
    exp_q.push_back(v.code);
    if (v.code == 8'd100) begin
      exp_q.push_back(v.w1[15:8]); exp_q.push_back(v.w1[7:0]);
      exp_q.push_back(v.w2[15:8]); exp_q.push_back(v.w2[7:0]);
      exp_q.push_back(v.res[15:8]); exp_q.push_back(v.res[7:0]);
    end
    wait_bytes(start + exp_q.size(), 2000);
    repeat (30) @(negedge clk);
    check({tag, "_len"}, rx_log.size() - start, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (start + k < rx_log.size())
        check($sformatf("%s_byte%0d", tag, k), rx_log[start+k], exp_q[k]);
    check({tag, "_weights"}, {weight1, weight2}, {v.w1, v.w2});
    check({tag, "_inputs"}, {input1, input2}, {v.i1, v.i2});
    check({tag, "_wwe"}, wwe_cnt - cw, v.wwe);
    check({tag, "_iwe"}, iwe_cnt - ci, v.iwe);
    check({tag, "_err"}, err_cnt - ce, v.err);
    if (v.wwe == 1) check({tag, "_wwe_align"}, we_w_seen, {v.w1, v.w2});
    if (v.iwe == 1) check({tag, "_iwe_align"}, we_i_seen, {v.i1, v.i2});
    m_w1 = v.w1; m_w2 = v.w2; m_i1 = v.i1; m_i2 = v.i2;
  endtask

  initial begin
    vec_t tbl [6];
    int start, ce, cw;
    logic [7:0] op;

    tbl[0] = mk(8'd5,  32'h0,        16'h0001, 8'd100, 16'h0,    16'h0,    16'h0,    16'h0,    0, 0, 0);
    tbl[1] = mk(8'd50, 32'h15AAFC33, 16'h0000, 8'd101, 16'h15AA, 16'hFC33, 16'h0,    16'h0,    1, 0, 0);
    tbl[2] = mk(8'd5,  32'h0,        16'hBEEF, 8'd100, 16'h15AA, 16'hFC33, 16'h0,    16'h0,    0, 0, 0);
    tbl[3] = mk(8'd51, 32'hE000200F, 16'h0000, 8'd101, 16'h15AA, 16'hFC33, 16'hE000, 16'h200F, 0, 1, 0);
    tbl[4] = mk(8'd7,  32'h0,        16'h0000, 8'd102, 16'h15AA, 16'hFC33, 16'hE000, 16'h200F, 0, 0, 1);
    tbl[5] = mk(8'd5,  32'h0,        16'h1234, 8'd100, 16'h15AA, 16'hFC33, 16'hE000, 16'h200F, 0, 0, 0);

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; result = 16'h0001;
    repeat (4) @(negedge clk);
    check("reset_tx", {tx_start, tx_data}, 9'd0);
    check("reset_regs", {weight1, weight2, input1, input2}, 64'd0);
    check("reset_pulses", {weights_we, inputs_we, pkt_error}, 3'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 6; t++) run_vec(tbl[t], $sformatf("tbl%0d", t));

    // Stalled payload: nothing may come back before the idle limit
    start = rx_log.size(); ce = err_cnt; cw = wwe_cnt;
    send_byte(8'd50); send_byte(8'h01); send_byte(8'h02);
    repeat (900) @(negedge clk);
    check("tmo_early", rx_log.size() - start, 0);
    repeat (200) @(negedge clk);
    check("tmo_len", rx_log.size() - start, 1);
    if (rx_log.size() > start) check("tmo_code", rx_log[start], 8'd102);
    check("tmo_err", err_cnt - ce, 1);
    check("tmo_wwe", wwe_cnt - cw, 0);
    check("tmo_weights", {weight1, weight2}, {m_w1, m_w2});
    run_vec(predict(8'd50, 32'h0A0B0C0D, 16'h5555), "tmo_next");

    // A READ arriving while a READ response is in flight is dropped
    start = rx_log.size();
    result = 16'h7777;
    send_byte(8'd5);
    repeat (12) @(negedge clk);
    send_byte(8'd5);
    wait_bytes(start + 7, 2000);
    repeat (200) @(negedge clk);
    check("inflight_len", rx_log.size() - start, 7);
    if (rx_log.size() >= start + 7) begin
      check("inflight_b0", rx_log[start], 8'd100);
      check("inflight_b1", rx_log[start+1], m_w1[15:8]);
      check("inflight_b6", rx_log[start+6], 8'h77);
    end

    // Reset while the third response byte is being offered
    start = rx_log.size();
    send_byte(8'd5);
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (tx_start && rx_log.size() == start + 2) break;
    end
    check("rst_pre_start", tx_start, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'd0);
    check("rst_regs_mid", {weight1, weight2, input1, input2}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_w1 = 0; m_w2 = 0; m_i1 = 0; m_i2 = 0;
    repeat (3) @(negedge clk);
    check("rst_bytes", rx_log.size() - start, 2);
    run_vec(predict(8'd5, 32'h0, 16'hA5C3), "post_rst_read");

    // Randomized packets against the reference
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: op = 8'd5;
        1: op = 8'd50;
        2: op = 8'd51;
        default: begin
          op = 8'($urandom_range(0, 255));
          while (op == 8'd5 || op == 8'd50 || op == 8'd51) op = 8'($urandom_range(0, 255));
        end
      endcase
      run_vec(predict(op, $urandom, 16'($urandom)), $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
